// File: rtl/parity_mem_pkg.sv
// Shared definitions for the parity-protected storage block: the parity
// generator and default widths.
package parity_mem_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

  // Callers zero-extend narrower words into this width, which leaves the XOR unchanged.
  localparam int PAR_MAX_W = 64;

  function automatic logic parity(input logic [PAR_MAX_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_err_track.sv
// Error bookkeeping: sticky flag, saturating error count and last failing
// address. A new error in the same cycle as a clear takes priority.
module parity_err_track #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              err,
  input  logic [ADDR_W-1:0] err_addr_in,
  input  logic              clr,
  output logic              sticky,
  output logic [CNT_W-1:0]  cnt,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              sticky_d, sticky_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q, cnt_base;
  logic [ADDR_W-1:0] addr_d, addr_q;

  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    cnt_base = clr ? '0 : cnt_q;
    if (err) begin
      sticky_d = 1'b1;
      addr_d   = err_addr_in;
      cnt_d    = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + CNT_W'(1);
    end else if (clr) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
      addr_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
    end
  end

  assign sticky = sticky_q;
  assign cnt    = cnt_q;
  assign addr   = addr_q;

endmodule

// File: rtl/parity_mem.sv
// Addressed storage with a parity bit per word: parity generated on write,
// checked on a one-cycle-latency read, with error reporting and fault injection.
module parity_mem
  import parity_mem_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = 16,
  parameter  int ODD    = 1,
  parameter  int CNT_W  = CNT_W_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [DATA_W-1:0] DIN,
  input  logic              INJ,
  input  logic              RD,
  input  logic [ADDR_W-1:0] RADDR,
  output logic [DATA_W-1:0] DOUT,
  output logic              POUT,
  output logic              RVALID,
  output logic              UNWR,
  output logic              ERROR,
  output logic              ERR_STICKY,
  output logic [CNT_W-1:0]  ERR_CNT,
  output logic [ADDR_W-1:0] ERR_ADDR,
  input  logic              CLR_ERR
);

  localparam logic              ODD_B   = (ODD != 0);
  localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              par_q [DEPTH];
  logic [DEPTH-1:0]  written_d, written_q;

  logic              wr_en, par_in;
  logic              rd_in_range, rd_hit;
  logic [DATA_W-1:0] rd_word;
  logic              rd_par;

  logic [DATA_W-1:0] dout_d, dout_q;
  logic              pout_d, pout_q;
  logic              rvalid_d, rvalid_q;
  logic              unwr_d, unwr_q;
  logic              error_d, error_q;

  always_comb begin
    wr_en  = WR && !RST && ({1'b0, WADDR} < DEPTH_V);
    par_in = parity(PAR_MAX_W'(DIN), ODD_B) ^ INJ;
    written_d = written_q;
    if (wr_en) written_d[WADDR] = 1'b1;
  end

  // Array contents are deliberately left unreset; the written bits gate every read.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[WADDR] <= DIN;
      par_q[WADDR] <= par_in;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) written_q <= '0;
    else     written_q <= written_d;
  end

  // Reads see pre-edge state, so a same-address write in this cycle is not observed.
  always_comb begin
    rd_in_range = ({1'b0, RADDR} < DEPTH_V);
    rd_hit      = rd_in_range && written_q[RADDR];
    rd_word     = mem_q[RADDR];
    rd_par      = par_q[RADDR];

    dout_d   = dout_q;
    pout_d   = pout_q;
    rvalid_d = 1'b0;
    unwr_d   = 1'b0;
    error_d  = 1'b0;
    if (RD) begin
      rvalid_d = 1'b1;
      if (rd_hit) begin
        dout_d  = rd_word;
        pout_d  = rd_par;
        error_d = (rd_par != parity(PAR_MAX_W'(rd_word), ODD_B));
      end else begin
        dout_d = '0;
        pout_d = 1'b0;
        unwr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dout_q   <= '0;
      pout_q   <= 1'b0;
      rvalid_q <= 1'b0;
      unwr_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      pout_q   <= pout_d;
      rvalid_q <= rvalid_d;
      unwr_q   <= unwr_d;
      error_q  <= error_d;
    end
  end

  parity_err_track #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_err_track (
    .clk         (CLK),
    .rst         (RST),
    .err         (error_d),
    .err_addr_in (RADDR),
    .clr         (CLR_ERR),
    .sticky      (ERR_STICKY),
    .cnt         (ERR_CNT),
    .addr        (ERR_ADDR)
  );

  assign DOUT   = dout_q;
  assign POUT   = pout_q;
  assign RVALID = rvalid_q;
  assign UNWR   = unwr_q;
  assign ERROR  = error_q;

endmodule

// File: tb/tb_parity_mem.sv
// Bench for parity_mem: directed scenarios plus random traffic checked against
// a cycle-level behavioural model of the storage and error bookkeeping.
module tb_parity_mem;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 12;
  localparam int ODD    = 1;
  localparam int CNT_W  = 2;
  localparam int ADDR_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              CLK = 1'b0;
  logic              RST, WR, INJ, RD, CLR_ERR;
  logic [ADDR_W-1:0] WADDR, RADDR;
  logic [DATA_W-1:0] DIN;
  logic [DATA_W-1:0] DOUT;
  logic              POUT, RVALID, UNWR, ERROR, ERR_STICKY;
  logic [CNT_W-1:0]  ERR_CNT;
  logic [ADDR_W-1:0] ERR_ADDR;

  parity_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ODD    (ODD),
    .CNT_W  (CNT_W)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .WR         (WR),
    .WADDR      (WADDR),
    .DIN        (DIN),
    .INJ        (INJ),
    .RD         (RD),
    .RADDR      (RADDR),
    .DOUT       (DOUT),
    .POUT       (POUT),
    .RVALID     (RVALID),
    .UNWR       (UNWR),
    .ERROR      (ERROR),
    .ERR_STICKY (ERR_STICKY),
    .ERR_CNT    (ERR_CNT),
    .ERR_ADDR   (ERR_ADDR),
    .CLR_ERR    (CLR_ERR)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_miscmp = 0;

  // Reference state: stored words, stored parity bits, written flags.
  int m_mem [16];
  int m_par [16];
  bit m_wr  [16];

  int e_dout, e_pout, e_rvalid, e_unwr, e_err, e_sticky, e_cnt, e_eaddr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Parity bit that makes data plus parity have the configured ones-count parity.
  function automatic int gen_par(input int data);
    int ones = $countones(data[DATA_W-1:0]);
    return ((ones % 2) == ODD) ? 0 : 1;
  endfunction

  task automatic model_edge(input bit wr, input int wa, input int din, input bit inj,
                            input bit rd, input int ra, input bit clr, input bit rst);
    if (rst) begin
      e_dout = 0; e_pout = 0; e_rvalid = 0; e_unwr = 0; e_err = 0;
      e_sticky = 0; e_cnt = 0; e_eaddr = 0;
      foreach (m_wr[i]) m_wr[i] = 1'b0;
      return;
    end
    e_rvalid = rd; e_unwr = 0; e_err = 0;
    if (rd) begin
      if (ra < DEPTH && m_wr[ra]) begin
        e_dout = m_mem[ra];
        e_pout = m_par[ra];
        e_err  = (($countones(m_mem[ra]) + m_par[ra]) % 2) != ODD;
      end else begin
        e_dout = 0; e_pout = 0; e_unwr = 1;
      end
    end
    if (e_err) begin
      e_sticky = 1;
      e_eaddr  = ra;
      e_cnt    = clr ? 1 : ((e_cnt < CNT_MAX) ? e_cnt + 1 : CNT_MAX);
    end else if (clr) begin
      e_sticky = 0; e_cnt = 0; e_eaddr = 0;
    end
    if (wr && wa < DEPTH) begin
      m_mem[wa] = din;
      m_par[wa] = gen_par(din) ^ int'(inj);
      m_wr[wa]  = 1'b1;
    end
  endtask

  task automatic step(input bit wr, input int wa, input int din, input bit inj,
                      input bit rd, input int ra, input bit clr, input bit rst);
    WR = wr; WADDR = ADDR_W'(wa); DIN = DATA_W'(din); INJ = inj;
    RD = rd; RADDR = ADDR_W'(ra); CLR_ERR = clr; RST = rst;
    @(posedge CLK);
    model_edge(wr, wa, din, inj, rd, ra, clr, rst);
    #1;
    chk("rvalid", 32'(RVALID), e_rvalid);
    chk("error", 32'(ERROR), e_err);
    chk("unwr", 32'(UNWR), e_unwr);
    chk("dout", 32'(DOUT), e_dout);
    chk("pout", 32'(POUT), e_pout);
    chk("err_sticky", 32'(ERR_STICKY), e_sticky);
    chk("err_cnt", 32'(ERR_CNT), e_cnt);
    chk("err_addr", 32'(ERR_ADDR), e_eaddr);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    e_dout = 0; e_pout = 0; e_rvalid = 0; e_unwr = 0; e_err = 0;
    e_sticky = 0; e_cnt = 0; e_eaddr = 0;
    foreach (m_mem[i]) begin m_mem[i] = 0; m_par[i] = 0; m_wr[i] = 1'b0; end

    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);

    // Unwritten location after reset.
    step(0, 0, 0, 0, 1, 3, 0, 0);
    chk("tp1_unwr", 32'(UNWR), 32'd1);
    chk("tp1_dout", 32'(DOUT), 32'd0);

    // Clean write/read, odd parity of 0xA5 needs a 1.
    step(1, 5, 'hA5, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 5, 0, 0);
    chk("tp2_dout", 32'(DOUT), 32'hA5);
    chk("tp2_pout", 32'(POUT), 32'd1);
    chk("tp2_error", 32'(ERROR), 32'd0);

    // Injected fault.
    step(1, 7, 'h01, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 7, 0, 0);
    chk("tp3_pout", 32'(POUT), 32'd1);
    chk("tp3_error", 32'(ERROR), 32'd1);
    chk("tp3_cnt", 32'(ERR_CNT), 32'd1);
    chk("tp3_addr", 32'(ERR_ADDR), 32'd7);
    idle();
    chk("tp3_pulse", 32'(ERROR), 32'd0);

    // Read-before-write on the same address.
    step(1, 2, 'hFF, 0, 0, 0, 0, 0);
    step(1, 2, 'h3C, 0, 1, 2, 0, 0);
    chk("tp4_old", 32'(DOUT), 32'hFF);
    step(0, 0, 0, 0, 1, 2, 0, 0);
    chk("tp4_new", 32'(DOUT), 32'h3C);

    // Saturation of the 2-bit counter, then a lone clear.
    step(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 7, 0, 0);
      chk("tp5_sat", 32'(ERR_CNT), (i < 3) ? i + 1 : 3);
    end
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("tp5_clr_cnt", 32'(ERR_CNT), 32'd0);
    chk("tp5_clr_sticky", 32'(ERR_STICKY), 32'd0);

    // Clear colliding with a new error: error wins.
    step(1, 9, 'h5A, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 7, 0, 0);
    step(0, 0, 0, 0, 1, 9, 1, 0);
    chk("tp6_cnt", 32'(ERR_CNT), 32'd1);
    chk("tp6_addr", 32'(ERR_ADDR), 32'd9);
    step(0, 0, 0, 0, 1, 9, 0, 1);
    chk("tp6_rst_rvalid", 32'(RVALID), 32'd0);
    step(0, 0, 0, 0, 1, 9, 0, 0);
    chk("tp6_unwr", 32'(UNWR), 32'd1);

    // Out-of-range addresses: writes dropped, reads unwritten.
    step(1, 13, 'h77, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 13, 0, 0);
    chk("oor_unwr", 32'(UNWR), 32'd1);

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255),
           ($urandom_range(0, 9) == 0), $urandom_range(0, 1), $urandom_range(0, 15),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/parity_mem.md
Name: parity_mem

Overview:
Clocked, parametrised parity-protected storage block for the parity generator → memory → checker → flag datapath. Generalises that chain to an addressed array:
- generates the parity bit on write and stores it with the data;
- checks data plus parity on read;
- raises a per-read error pulse, a sticky error flag, a saturating error counter and the last failing address.

Also provides a parity-bit corruption input so the bench can inject faults.

Parameters:
DATA_W, 8, data word width in bits (≥1)
DEPTH, 16, number of stored words (≥2)
ADDR_W, $clog2(DEPTH), address width (derived; not overridden)
ODD, 1, 1 = odd parity (data plus parity has an odd number of ones), 0 = even parity
CNT_W, 8, error counter width

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous active-high reset
WR  input  1  write strobe, sampled at CLK edge
WADDR  input  ADDR_W  write address
DIN  input  DATA_W  write data
INJ  input  1  when high with WR, the stored parity bit is inverted (fault injection)
RD  input  1  read strobe, sampled at CLK edge
RADDR  input  ADDR_W  read address
DOUT  output  DATA_W  registered read data
POUT  output  1  registered stored parity bit of the read word
RVALID  output  1  one-cycle pulse, DOUT/POUT/ERROR valid
UNWR  output  1  with RVALID: the location was never written since reset
ERROR  output  1  one-cycle pulse with RVALID when the parity check fails
ERR_STICKY  output  1  set by any ERROR, held until CLR_ERR or RST
ERR_CNT  output  CNT_W  saturating count of ERROR pulses
ERR_ADDR  output  ADDR_W  address of the most recent failing read
CLR_ERR  input  1  synchronous clear of ERR_STICKY, ERR_CNT and ERR_ADDR

Behaviour:
- Reset (RST=1 at an edge):
  - DOUT=0, POUT=0, RVALID=0, UNWR=0, ERROR=0, ERR_STICKY=0, ERR_CNT=0, ERR_ADDR=0.
  - All per-entry written bits are cleared.
  - Array data contents are not reset.
  - RST overrides WR, RD and CLR_ERR in the same cycle.
- Write (WR=1 at edge k):
  - mem[WADDR] <= DIN.
  - par[WADDR] <= P(DIN) ^ INJ, where P = ^DIN ^ ODD.
  - written[WADDR] <= 1.
  - The new data is visible to reads sampled at edge k+1 and later.
- Read (RD=1 at edge k): read latency is exactly 1 cycle. After edge k:
  - RVALID=1;
  - DOUT=mem[RADDR], POUT=par[RADDR];
  - UNWR=~written[RADDR];
  - ERROR = written[RADDR] & ((^mem[RADDR] ^ par[RADDR]) != ODD).
- Unwritten location read: DOUT=0, POUT=0, UNWR=1, ERROR=0. It is never counted as an error.
- No read (RD=0): RVALID=0, ERROR=0, UNWR=0. DOUT and POUT hold their last value.
- WR and RD in the same cycle to the same address: read-before-write. The read returns the old word, old parity and old written bit. Different addresses are independent.
- Error bookkeeping, updated at the same edge ERROR is registered:
  - ERR_STICKY <= 1.
  - ERR_ADDR <= RADDR.
  - ERR_CNT <= ERR_CNT + 1, saturating at 2^CNT_W−1 with no wrap.
- CLR_ERR with a new error in the same cycle: the error wins. Result is ERR_STICKY=1, ERR_CNT=1, ERR_ADDR=the failing address.
- CLR_ERR with no new error: ERR_STICKY=0, ERR_CNT=0, ERR_ADDR=0.
- Out-of-range addresses when DEPTH is not a power of two:
  - writes are ignored;
  - reads return DOUT=0, UNWR=1, ERROR=0.
- Reset mid-operation: a read sampled in the same cycle as RST produces no RVALID. All written bits clear, so later reads report UNWR=1 until the locations are rewritten.

Decomposition:
- Package parity_mem_pkg holds:
  - function parity(data, odd), the reduction-XOR parity generator;
  - the default localparams DATA_W_DEF=8 and CNT_W_DEF=8.
- One natural sub-module, parity_err_track: ERR_STICKY, ERR_CNT with saturation, ERR_ADDR and CLR_ERR priority.
- The array, written bits and read register stay in parity_mem.

Test Plan:
- Reset, then RD addr 3 → RVALID=1, UNWR=1, ERROR=0, DOUT=0 one cycle later; ERR_CNT=0.
- ODD=1: WR addr 5 DIN=8'hA5 (4 ones), then RD 5 → DOUT=8'hA5, POUT=1, ERROR=0, ERR_STICKY=0.
- WR addr 7 DIN=8'h01 with INJ=1, then RD 7 → POUT=1, ERROR=1 for one cycle, ERR_STICKY=1, ERR_CNT=1, ERR_ADDR=7.
- Same-cycle WR and RD addr 2: DIN=8'h3C over old 8'hFF → DOUT=8'hFF. Next RD 2 → DOUT=8'h3C, ERROR=0.
- CNT_W=2: four injected-error reads → ERR_CNT=1,2,3,3 (saturates). Then CLR_ERR alone → ERR_CNT=0, ERR_STICKY=0, ERR_ADDR=0.
- CLR_ERR in the same cycle as an injected-error read of addr 9 → ERR_CNT=1, ERR_STICKY=1, ERR_ADDR=9. Then RST → all outputs 0 and a read of addr 9 gives UNWR=1.
